// File: rtl/logic_serial_seq.sv
// Bit-serial sequencer feeding a 1-bit AND/OR/XOR gate slice, LSB first, and
// reassembling its output. Optional flags are built with LOGIC_SEQ_FLAGS_EN.
module logic_serial_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             slice_a,
    output logic             slice_b,
    output logic [1:0]       slice_ctrl,
    input  logic             slice_out,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, sr, result_q;
    logic [WIDTH-1:0] sr_nx;
    logic             accept, last;

    // Handshake: a request is taken on any rising edge where start=1 and
    // ready=1 (IDLE only); start in any other state is dropped, never queued.
    assign accept    = (state == IDLE) && start;
    assign last      = (state == SHIFT) && (cnt == LAST);
    assign sr_nx     = {slice_out, sr[WIDTH-1:1]};
    assign result    = result_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        done       = 1'b0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_ctrl = 2'b00;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                slice_a    = a_q[cnt];
                slice_b    = b_q[cnt];
                slice_ctrl = op_q;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The final shift is folded straight into result so it is valid with done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            sr       <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt  <= '0;
                op_q <= op;
                a_q  <= opa;
                b_q  <= opb;
            end
            if (state == SHIFT) begin
                sr  <= sr_nx;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (last) result_q <= sr_nx;
        end
    end

`ifdef LOGIC_SEQ_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (last) begin
            zero_q <= (sr_nx == '0);
            neg_q  <= sr_nx[WIDTH-1];
        end
    end

    assign zero     = zero_q;
    assign negative = neg_q;
`else
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule
